// File: rtl/vape_multi_region_monitor.sv
// vape_multi_region_monitor: per-region proof-of-execution monitor for openMSP430.
// Tracks NUM_REG executable regions, each with its own output region, and
// raises exec[i] once region i ran atomically from ER_min to ER_max with no
// tampering. The META window and secure ROM are protected for every channel.
// Optional feature macro: VAPE_VIOL_LOG_EN adds the viol_cause port, which
// holds the code of the last violation per channel.
module vape_multi_region_monitor #(
  parameter int unsigned NUM_REG   = 2,
  parameter logic [15:0] META_MIN  = 16'hFF00,
  parameter logic [15:0] META_MAX  = 16'hFF07,
  parameter logic [15:0] SMEM_BASE = 16'hA000,
  parameter logic [15:0] SMEM_SIZE = 16'h4000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [15:0]             pc,
  input  logic                    data_en,
  input  logic                    data_wr,
  input  logic [15:0]             data_addr,
  input  logic                    dma_en,
  input  logic [15:0]             dma_addr,
  input  logic                    irq,
  input  logic [16*NUM_REG-1:0]   er_min_bus,
  input  logic [16*NUM_REG-1:0]   er_max_bus,
  input  logic [16*NUM_REG-1:0]   or_min_bus,
  input  logic [16*NUM_REG-1:0]   or_max_bus,
  output logic [NUM_REG-1:0]      exec,
  output logic                    exec_any
`ifdef VAPE_VIOL_LOG_EN
  ,
  output logic [3*NUM_REG-1:0]    viol_cause
`endif
);

  localparam int unsigned AW = 16;
  localparam int unsigned CW = 3;
  // One past the last secure ROM address; 17 bits so BASE+SIZE cannot wrap.
  localparam logic [AW:0] SMEM_END = 17'(SMEM_BASE) + 17'(SMEM_SIZE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Unsigned inclusive range test.
  function automatic logic in_rng(input logic [AW-1:0] a,
                                  input logic [AW-1:0] lo,
                                  input logic [AW-1:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

  logic [AW-1:0] r_prev_pc;
  logic          w_cpu_wr;
  logic          w_data_sys;
  logic          w_dma_sys;

  assign w_cpu_wr = data_en & data_wr;

  // Addresses that are write-protected for every channel (META window, secure ROM).
  assign w_data_sys = in_rng(data_addr, META_MIN, META_MAX) ||
                      ((data_addr >= SMEM_BASE) && (17'(data_addr) < SMEM_END));
  assign w_dma_sys  = in_rng(dma_addr, META_MIN, META_MAX) ||
                      ((dma_addr >= SMEM_BASE) && (17'(dma_addr) < SMEM_END));

  // Previous instruction address, shared by all channels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_prev_pc <= '0;
    else          r_prev_pc <= pc;
  end

  for (genvar gi = 0; gi < NUM_REG; gi++) begin : g_ch
    logic [AW-1:0]   w_er_min, w_er_max, w_or_min, w_or_max;
    logic [4*AW-1:0] w_cfg;
    logic [4*AW-1:0] r_cfg_shadow;
    state_t          r_state, w_state_nxt;
    logic            w_pc_in_er, w_ppc_in_er, w_run;
    logic            w_v_prot, w_v_or, w_v_irq, w_v_dma;
    logic            w_v_exit, w_v_entry, w_v_cfg, w_viol;
    logic            w_exec_ch;

    assign w_er_min = er_min_bus[AW*gi +: AW];
    assign w_er_max = er_max_bus[AW*gi +: AW];
    assign w_or_min = or_min_bus[AW*gi +: AW];
    assign w_or_max = or_max_bus[AW*gi +: AW];
    assign w_cfg    = {w_er_min, w_er_max, w_or_min, w_or_max};

    assign w_pc_in_er  = in_rng(pc, w_er_min, w_er_max);
    assign w_ppc_in_er = in_rng(r_prev_pc, w_er_min, w_er_max);
    assign w_run       = (r_state == S_RUN);

    // Individual violation terms; any one of them aborts the channel.
    assign w_v_prot  = (w_cpu_wr && (in_rng(data_addr, w_er_min, w_er_max) || w_data_sys)) ||
                       (dma_en   && (in_rng(dma_addr,  w_er_min, w_er_max) || w_dma_sys));
    assign w_v_or    = (w_cpu_wr && in_rng(data_addr, w_or_min, w_or_max) && !w_pc_in_er) ||
                       (dma_en   && in_rng(dma_addr,  w_or_min, w_or_max));
    assign w_v_irq   = w_run && irq;
    assign w_v_dma   = w_run && dma_en;
    assign w_v_exit  = w_run && !w_pc_in_er && (r_prev_pc != w_er_max);
    assign w_v_entry = w_run && w_pc_in_er && !w_ppc_in_er && (pc != w_er_min);
    assign w_v_cfg   = (w_cfg != r_cfg_shadow) || (w_er_min > w_er_max) || (w_or_min > w_or_max);
    assign w_viol    = w_v_prot | w_v_or | w_v_irq | w_v_dma | w_v_exit | w_v_entry | w_v_cfg;

    // Config shadow reloads every cycle so any edit shows up as a one-cycle mismatch.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_cfg_shadow <= '0;
      else          r_cfg_shadow <= w_cfg;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
    end

    // FSM next state; a violation overrides every other transition.
    always_comb begin
      w_state_nxt = r_state;
      if (w_viol) begin
        w_state_nxt = S_IDLE;
      end else begin
        case (r_state)
          S_IDLE:  if (pc == w_er_min) w_state_nxt = S_RUN;
          S_RUN:   if ((r_prev_pc == w_er_max) && !w_pc_in_er) w_state_nxt = S_DONE;
          S_DONE:  if (pc == w_er_min) w_state_nxt = S_RUN;
          default: w_state_nxt = S_IDLE;
        endcase
      end
    end

    // FSM output decode: proof flag is a pure decode of the state flops.
    always_comb begin
      w_exec_ch = 1'b0;
      if (r_state == S_DONE) w_exec_ch = 1'b1;
    end

    assign exec[gi] = w_exec_ch;

`ifdef VAPE_VIOL_LOG_EN
    logic [CW-1:0] w_code;
    logic [CW-1:0] r_cause;

    // Lowest code wins when several violations coincide.
    always_comb begin
      w_code = CW'(0);
      if      (w_v_prot)  w_code = CW'(1);
      else if (w_v_or)    w_code = CW'(2);
      else if (w_v_irq)   w_code = CW'(3);
      else if (w_v_dma)   w_code = CW'(4);
      else if (w_v_exit)  w_code = CW'(5);
      else if (w_v_entry) w_code = CW'(6);
      else if (w_v_cfg)   w_code = CW'(7);
    end

    // Latch the cause on each violation; a fresh entry into RUN clears it.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                     r_cause <= '0;
      else if (w_viol)                                  r_cause <= w_code;
      else if ((w_state_nxt == S_RUN) && (r_state != S_RUN)) r_cause <= '0;
    end

    assign viol_cause[CW*gi +: CW] = r_cause;
`endif
  end

  assign exec_any = |exec;

endmodule

// File: tb/tb_vape_multi_region_monitor.sv
// Self-checking bench for vape_multi_region_monitor with two channels.
// Expected results are queued as each stimulus is applied and popped when
// the DUT output is sampled one time unit after the clock edge.
module tb_vape_multi_region_monitor;

  localparam int unsigned NR = 2;

  logic              clk;
  logic              reset_n;
  logic [15:0]       pc;
  logic              data_en, data_wr;
  logic [15:0]       data_addr;
  logic              dma_en;
  logic [15:0]       dma_addr;
  logic              irq;
  logic [16*NR-1:0]  er_min_bus, er_max_bus, or_min_bus, or_max_bus;
  logic [NR-1:0]     exec;
  logic              exec_any;
`ifdef VAPE_VIOL_LOG_EN
  logic [3*NR-1:0]   viol_cause;
`endif

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [NR-1:0] exec;
    logic          any;
    logic          use_cause;
    logic [2:0]    cause0;
    string         tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  vape_multi_region_monitor #(.NUM_REG(NR)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pc         (pc),
    .data_en    (data_en),
    .data_wr    (data_wr),
    .data_addr  (data_addr),
    .dma_en     (dma_en),
    .dma_addr   (dma_addr),
    .irq        (irq),
    .er_min_bus (er_min_bus),
    .er_max_bus (er_max_bus),
    .or_min_bus (or_min_bus),
    .or_max_bus (or_max_bus),
    .exec       (exec),
    .exec_any   (exec_any)
`ifdef VAPE_VIOL_LOG_EN
    ,
    .viol_cause (viol_cause)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step pc through an ER-like range, one instruction per cycle.
  task automatic walk(input logic [15:0] lo, input logic [15:0] hi);
    for (int a = int'(lo); a <= int'(hi); a += 2) begin
      pc = 16'(a);
      tick();
    end
  endtask

  function automatic exp_t mk(input logic [NR-1:0] ex, input logic any,
                              input logic uc, input logic [2:0] c0, input string tag);
    exp_t t;
    t.exec = ex; t.any = any; t.use_cause = uc; t.cause0 = c0; t.tag = tag;
    return t;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(mk(2'b00, 1'b0, 1'b1, 3'd0, "reset"));
    e = sb.pop_front();
    n_chk++;
    if ({exec_any, exec} !== {e.any, e.exec}) begin
      n_err++; $display("FAIL %s: any/exec got %b/%b exp %b/%b", e.tag, exec_any, exec, e.any, e.exec);
    end
`ifdef VAPE_VIOL_LOG_EN
    n_chk++;
    if (viol_cause !== 6'd0) begin
      n_err++; $display("FAIL %s_cause: got %h exp 0", e.tag, viol_cause);
    end
`endif
    reset_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_exec_basic();
    pc = 16'hF000; tick();
    sb.push_back(mk(2'b00, 1'b0, 1'b1, 3'd0, "enter_run"));
    pc = 16'hE000; tick();
    e = sb.pop_front();
    n_chk++;
    if ({exec_any, exec} !== {e.any, e.exec}) begin
      n_err++; $display("FAIL %s: any/exec got %b/%b exp %b/%b", e.tag, exec_any, exec, e.any, e.exec);
    end
`ifdef VAPE_VIOL_LOG_EN
    n_chk++;
    if (viol_cause[2:0] !== e.cause0) begin
      n_err++; $display("FAIL %s_cause: got %0d exp %0d", e.tag, viol_cause[2:0], e.cause0);
    end
`endif
    walk(16'hE002, 16'hE0FC);
    sb.push_back(mk(2'b00, 1'b0, 1'b0, 3'd0, "at_er_max"));
    pc = 16'hE0FE; tick();
    e = sb.pop_front();
    n_chk++;
    if ({exec_any, exec} !== {e.any, e.exec}) begin
      n_err++; $display("FAIL %s: any/exec got %b/%b exp %b/%b", e.tag, exec_any, exec, e.any, e.exec);
    end
    sb.push_back(mk(2'b01, 1'b1, 1'b1, 3'd0, "exec_rise"));
    pc = 16'hF000; tick();
    e = sb.pop_front();
    n_chk++;
    if ({exec_any, exec} !== {e.any, e.exec}) begin
      n_err++; $display("FAIL %s: any/exec got %b/%b exp %b/%b", e.tag, exec_any, exec, e.any, e.exec);
    end
    sb.push_back(mk(2'b01, 1'b1, 1'b0, 3'd0, "done_hold"));
    pc = 16'hF002; tick();
    e = sb.pop_front();
    n_chk++;
    if ({exec_any, exec} !== {e.any, e.exec}) begin
      n_err++; $display("FAIL %s: any/exec got %b/%b exp %b/%b", e.tag, exec_any, exec, e.any, e.exec);
    end
  endtask

  task automatic test_or_write();
    sb.push_back(mk(2'b00, 1'b0, 1'b1, 3'd2, "or_wr_outside"));
    pc = 16'hF100; data_en = 1'b1; data_wr = 1'b1; data_addr = 16'h0404;
    tick();
    data_en = 1'b0; data_wr = 1'b0;
    e = sb.pop_front();
    n_chk++;
    if ({exec_any, exec} !== {e.any, e.exec}) begin
      n_err++; $display("FAIL %s: any/exec got %b/%b exp %b/%b", e.tag, exec_any, exec, e.any, e.exec);
    end
`ifdef VAPE_VIOL_LOG_EN
    n_chk++;
    if (viol_cause[2:0] !== e.cause0) begin
      n_err++; $display("FAIL %s_cause: got %0d exp %0d", e.tag, viol_cause[2:0], e.cause0);
    end
`endif
    pc = 16'hE000; tick();
    walk(16'hE002, 16'hE01E);
    sb.push_back(mk(2'b00, 1'b0, 1'b1, 3'd0, "or_wr_inside"));
    pc = 16'hE020; data_en = 1'b1; data_wr = 1'b1; data_addr = 16'h0404;
    tick();
    data_en = 1'b0; data_wr = 1'b0;
    e = sb.pop_front();
    n_chk++;
    if ({exec_any, exec} !== {e.any, e.exec}) begin
      n_err++; $display("FAIL %s: any/exec got %b/%b exp %b/%b", e.tag, exec_any, exec, e.any, e.exec);
    end
`ifdef VAPE_VIOL_LOG_EN
    n_chk++;
    if (viol_cause[2:0] !== e.cause0) begin
      n_err++; $display("FAIL %s_cause: got %0d exp %0d", e.tag, viol_cause[2:0], e.cause0);
    end
`endif
    walk(16'hE022, 16'hE0FE);
    sb.push_back(mk(2'b01, 1'b1, 1'b0, 3'd0, "or_wr_inside_done"));
    pc = 16'hF000; tick();
    e = sb.pop_front();
    n_chk++;
    if ({exec_any, exec} !== {e.any, e.exec}) begin
      n_err++; $display("FAIL %s: any/exec got %b/%b exp %b/%b", e.tag, exec_any, exec, e.any, e.exec);
    end
  endtask

  task automatic test_irq();
    sb.push_back(mk(2'b00, 1'b0, 1'b0, 3'd0, "rerun_clears"));
    pc = 16'hE000; tick();
    e = sb.pop_front();
    n_chk++;
    if ({exec_any, exec} !== {e.any, e.exec}) begin
      n_err++; $display("FAIL %s: any/exec got %b/%b exp %b/%b", e.tag, exec_any, exec, e.any, e.exec);
    end
    walk(16'hE002, 16'hE00E);
    sb.push_back(mk(2'b00, 1'b0, 1'b1, 3'd3, "irq_run"));
    pc = 16'hE010; irq = 1'b1; tick();
    irq = 1'b0;
    e = sb.pop_front();
    n_chk++;
    if ({exec_any, exec} !== {e.any, e.exec}) begin
      n_err++; $display("FAIL %s: any/exec got %b/%b exp %b/%b", e.tag, exec_any, exec, e.any, e.exec);
    end
`ifdef VAPE_VIOL_LOG_EN
    n_chk++;
    if (viol_cause[2:0] !== e.cause0) begin
      n_err++; $display("FAIL %s_cause: got %0d exp %0d", e.tag, viol_cause[2:0], e.cause0);
    end
`endif
    walk(16'hE012, 16'hE0FE);
    sb.push_back(mk(2'b00, 1'b0, 1'b0, 3'd3, "irq_no_done"));
    pc = 16'hF000; tick();
    e = sb.pop_front();
    n_chk++;
    if ({exec_any, exec} !== {e.any, e.exec}) begin
      n_err++; $display("FAIL %s: any/exec got %b/%b exp %b/%b", e.tag, exec_any, exec, e.any, e.exec);
    end
  endtask

  task automatic test_dma_isolation();
    pc = 16'hE000; tick();
    walk(16'hE002, 16'hE0FE);
    pc = 16'hF000; tick();
    pc = 16'h2000; tick();
    walk(16'h2002, 16'h20FE);
    sb.push_back(mk(2'b11, 1'b1, 1'b0, 3'd0, "both_done"));
    pc = 16'h3000; tick();
    e = sb.pop_front();
    n_chk++;
    if ({exec_any, exec} !== {e.any, e.exec}) begin
      n_err++; $display("FAIL %s: any/exec got %b/%b exp %b/%b", e.tag, exec_any, exec, e.any, e.exec);
    end
    sb.push_back(mk(2'b10, 1'b1, 1'b1, 3'd1, "dma_er"));
    dma_en = 1'b1; dma_addr = 16'hE050; tick();
    dma_en = 1'b0;
    e = sb.pop_front();
    n_chk++;
    if ({exec_any, exec} !== {e.any, e.exec}) begin
      n_err++; $display("FAIL %s: any/exec got %b/%b exp %b/%b", e.tag, exec_any, exec, e.any, e.exec);
    end
`ifdef VAPE_VIOL_LOG_EN
    n_chk++;
    if (viol_cause[2:0] !== e.cause0) begin
      n_err++; $display("FAIL %s_cause: got %0d exp %0d", e.tag, viol_cause[2:0], e.cause0);
    end
    n_chk++;
    if (viol_cause[5:3] !== 3'd0) begin
      n_err++; $display("FAIL ch1_cause_kept: got %0d exp 0", viol_cause[5:3]);
    end
`endif
  endtask

  task automatic test_entry_exit();
    pc = 16'hF000; tick();
    sb.push_back(mk(2'b10, 1'b1, 1'b1, 3'd1, "mid_entry"));
    pc = 16'hE008; tick();
    e = sb.pop_front();
    n_chk++;
    if ({exec_any, exec} !== {e.any, e.exec}) begin
      n_err++; $display("FAIL %s: any/exec got %b/%b exp %b/%b", e.tag, exec_any, exec, e.any, e.exec);
    end
    walk(16'hE00A, 16'hE0FE);
    sb.push_back(mk(2'b10, 1'b1, 1'b0, 3'd0, "mid_entry_no_done"));
    pc = 16'hF000; tick();
    e = sb.pop_front();
    n_chk++;
    if ({exec_any, exec} !== {e.any, e.exec}) begin
      n_err++; $display("FAIL %s: any/exec got %b/%b exp %b/%b", e.tag, exec_any, exec, e.any, e.exec);
    end
    pc = 16'hE000; tick();
    walk(16'hE002, 16'hE040);
    sb.push_back(mk(2'b10, 1'b1, 1'b1, 3'd5, "early_exit"));
    pc = 16'hF000; tick();
    e = sb.pop_front();
    n_chk++;
    if ({exec_any, exec} !== {e.any, e.exec}) begin
      n_err++; $display("FAIL %s: any/exec got %b/%b exp %b/%b", e.tag, exec_any, exec, e.any, e.exec);
    end
`ifdef VAPE_VIOL_LOG_EN
    n_chk++;
    if (viol_cause[2:0] !== e.cause0) begin
      n_err++; $display("FAIL %s_cause: got %0d exp %0d", e.tag, viol_cause[2:0], e.cause0);
    end
`endif
  endtask

  task automatic test_cfg();
    pc = 16'hE000; tick();
    walk(16'hE002, 16'hE0FE);
    sb.push_back(mk(2'b11, 1'b1, 1'b0, 3'd0, "cfg_pre"));
    pc = 16'hF000; tick();
    e = sb.pop_front();
    n_chk++;
    if ({exec_any, exec} !== {e.any, e.exec}) begin
      n_err++; $display("FAIL %s: any/exec got %b/%b exp %b/%b", e.tag, exec_any, exec, e.any, e.exec);
    end
    sb.push_back(mk(2'b10, 1'b1, 1'b1, 3'd7, "cfg_change"));
    er_max_bus[15:0] = 16'hE100; tick();
    e = sb.pop_front();
    n_chk++;
    if ({exec_any, exec} !== {e.any, e.exec}) begin
      n_err++; $display("FAIL %s: any/exec got %b/%b exp %b/%b", e.tag, exec_any, exec, e.any, e.exec);
    end
`ifdef VAPE_VIOL_LOG_EN
    n_chk++;
    if (viol_cause[2:0] !== e.cause0) begin
      n_err++; $display("FAIL %s_cause: got %0d exp %0d", e.tag, viol_cause[2:0], e.cause0);
    end
`endif
    er_max_bus[15:0] = 16'hE0FE; tick();
    tick();
    or_min_bus[15:0] = 16'h0410; tick();
    tick();
    pc = 16'hE000; tick();
    walk(16'hE002, 16'hE0FE);
    sb.push_back(mk(2'b10, 1'b1, 1'b1, 3'd7, "cfg_invalid_held"));
    pc = 16'hF000; tick();
    e = sb.pop_front();
    n_chk++;
    if ({exec_any, exec} !== {e.any, e.exec}) begin
      n_err++; $display("FAIL %s: any/exec got %b/%b exp %b/%b", e.tag, exec_any, exec, e.any, e.exec);
    end
`ifdef VAPE_VIOL_LOG_EN
    n_chk++;
    if (viol_cause[2:0] !== e.cause0) begin
      n_err++; $display("FAIL %s_cause: got %0d exp %0d", e.tag, viol_cause[2:0], e.cause0);
    end
`endif
    or_min_bus[15:0] = 16'h0400; tick();
    tick();
  endtask

  task automatic test_async_reset();
    pc = 16'hE000; tick();
    walk(16'hE002, 16'hE0FE);
    sb.push_back(mk(2'b11, 1'b1, 1'b0, 3'd0, "pre_reset"));
    pc = 16'hF000; tick();
    e = sb.pop_front();
    n_chk++;
    if ({exec_any, exec} !== {e.any, e.exec}) begin
      n_err++; $display("FAIL %s: any/exec got %b/%b exp %b/%b", e.tag, exec_any, exec, e.any, e.exec);
    end
    #2;
    sb.push_back(mk(2'b00, 1'b0, 1'b1, 3'd0, "async_reset"));
    reset_n = 1'b0;
    #1;
    e = sb.pop_front();
    n_chk++;
    if ({exec_any, exec} !== {e.any, e.exec}) begin
      n_err++; $display("FAIL %s: any/exec got %b/%b exp %b/%b", e.tag, exec_any, exec, e.any, e.exec);
    end
`ifdef VAPE_VIOL_LOG_EN
    n_chk++;
    if (viol_cause !== 6'd0) begin
      n_err++; $display("FAIL %s_cause: got %h exp 0", e.tag, viol_cause);
    end
`endif
    tick();
    reset_n = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    reset_n    = 1'b0;
    pc         = 16'h0000;
    data_en    = 1'b0;
    data_wr    = 1'b0;
    data_addr  = 16'h0000;
    dma_en     = 1'b0;
    dma_addr   = 16'h0000;
    irq        = 1'b0;
    er_min_bus = {16'h2000, 16'hE000};
    er_max_bus = {16'h20FE, 16'hE0FE};
    or_min_bus = {16'h0500, 16'h0400};
    or_max_bus = {16'h050F, 16'h040F};

    test_reset();
    test_exec_basic();
    test_or_write();
    test_irq();
    test_dma_isolation();
    test_entry_exit();
    test_cfg();
    test_async_reset();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vape_multi_region_monitor.md
Name: vape_multi_region_monitor

Overview:
- Parametrised successor of the single-region VAPE execution monitor.
- Tracks NUM_REG independent executable regions (ER), each with its own output region (OR). Each region has a per-region registered EXEC flag that proves the region executed atomically and unmodified, with untampered output.
- Sits beside the openMSP430 core on the frontend/memory-backbone taps. All checks run in parallel per channel; a shared META window is protected globally.

Parameters:
- NUM_REG, 2, number of independent ER/OR channels (1..8)
- META_MIN, 16'hFF00, first address of the protected metadata window
- META_MAX, 16'hFF07, last address of the protected metadata window
- SMEM_BASE, 16'hA000, base of secure ROM; writes there are a violation for all channels
- SMEM_SIZE, 16'h4000, size of secure ROM

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- pc  input  16  current instruction address
- data_en  input  1  CPU data access strobe
- data_wr  input  1  CPU data write qualifier
- data_addr  input  16  CPU data address
- dma_en  input  1  DMA access strobe
- dma_addr  input  16  DMA address
- irq  input  1  interrupt taken
- er_min_bus  input  16*NUM_REG  packed ER start addresses; channel i at [16i+15:16i]
- er_max_bus  input  16*NUM_REG  packed ER last-instruction addresses
- or_min_bus  input  16*NUM_REG  packed OR start addresses
- or_max_bus  input  16*NUM_REG  packed OR end addresses
- exec  output  NUM_REG  per-channel proof-of-execution flag, registered
- exec_any  output  1  OR of exec
- viol_cause  output  3*NUM_REG  per-channel last violation code; present only with the optional feature

Behaviour:
- Shared register: prev_pc (16b). Reset value 0. Loads pc every cycle.
- cpu_wr = data_en & data_wr.
- in_X(a) = X_min <= a <= X_max, unsigned, inclusive.
- Per-channel FSM states: IDLE, RUN, DONE. exec[i] = (state==DONE).
- Reset: all channels IDLE, exec=0, exec_any=0, cfg shadow=0, viol_cause=0.
- Per-channel violations, any of which is true in a cycle:
  - cpu_wr or dma_en to an address in ER, the META window, or SMEM.
  - cpu_wr to OR while pc is not in ER.
  - dma_en to OR.
  - irq or dma_en while state==RUN.
  - In RUN: pc leaves ER while prev_pc != ER_max.
  - In RUN: pc enters ER at an address other than ER_min from outside, i.e. prev_pc not in ER and pc != ER_min.
  - Config change: the channel's {er_min, er_max, or_min, or_max} differs from its shadow register. The shadow reloads every cycle.
  - Invalid config: ER_min > ER_max or OR_min > OR_max. The channel is held in IDLE while invalid.
- Transitions (violation has priority over all others):
  - Any state, violation -> IDLE.
  - IDLE, pc==ER_min -> RUN.
  - RUN, prev_pc==ER_max and pc not in ER -> DONE.
  - DONE, pc==ER_min -> RUN; exec drops on that edge, so re-execution clears the proof.
  - DONE, otherwise -> stays DONE.
- Latency:
  - exec rises on the clock edge that samples the first out-of-ER pc after ER_max.
  - exec falls on the edge that samples the violation.
  - No combinational path from inputs to exec.
- Overlap: channels are evaluated independently. A write into channel j's ER violates channel j only.
- Reset mid-RUN: asynchronous clear to IDLE; exec=0 immediately.

Optional Feature:
- Macro: VAPE_VIOL_LOG_EN.
- Enabled:
  - viol_cause[i] latches a code on each violation edge: 1=ER/META/SMEM write, 2=OR write, 3=irq, 4=dma during RUN, 5=illegal exit, 6=illegal entry, 7=config change/invalid.
  - The lowest code wins on simultaneous violations.
  - Entering RUN clears viol_cause to 0.
- Disabled: the viol_cause port and its logic are absent; FSM behaviour is identical.

Test Plan:
- NUM_REG=2, ch0 ER=E000..E0FE, OR=0400..040F. pc walks E000,E002..E0FE then F000 -> exec=2'b01 on the F000 sample edge; exec_any=1.
- Ch0 in RUN, irq=1 at pc=E010 -> exec[0] stays 0 and ch0 returns to IDLE; with VAPE_VIOL_LOG_EN, viol_cause[2:0]=3.
- Ch0 DONE, cpu_wr to 0x0404 from pc=F100 -> exec[0]=0 next edge; cause 2. The same write from pc=E020 during RUN is no violation.
- Ch0 DONE, dma_en with dma_addr=E050 -> exec[0]=0; a concurrent ch1 in DONE with disjoint ER/OR keeps exec[1]=1.
- Jump from F000 to E008 (not ER_min) -> ch0 stays IDLE; jump out from E040 to F000 during RUN -> IDLE, cause 5.
- reset_n low while ch0 DONE -> exec=0 asynchronously. Changing er_max_bus ch0 to E100 while DONE -> exec[0]=0, cause 7.
